uart_piso: RTL

Parallel-in, serial-out UART transmitter: the transmit-side counterpart of the `sipo` receiver, driving the line that a `sipo` instance samples. Accepts one CHAR_W-bit character per valid/ready handshake. Serialises it as start bit, data LSB first, optional even parity, then one stop bit, at one bit per DIVIDER clocks. Lives on the same 50 MHz domain, so loopback into `sipo` with a matching DIVIDER must recover the character.

---
 rtl/uart_piso.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_piso.sv
// Parallel-in, serial-out UART transmitter: start bit, CHAR_W data bits LSB first,
// optional even parity (enabled by defining UART_PISO_PARITY_EN), one stop bit.
module uart_piso #(
    parameter int DIVIDER   = 4096,
    parameter int CHAR_W    = 8,
    parameter int COUNTER_W = $clog2(DIVIDER),
    parameter int INDEX_W   = $clog2(CHAR_W) + 1
) (
    input  logic              clock_50M,
    input  logic              n_reset,
    input  logic [CHAR_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_tx_pin,
    output logic              tx_busy,
    output logic              tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PISO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [COUNTER_W-1:0] cnt_q, cnt_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;
    logic [CHAR_W-1:0]    shift_q, shift_d;
    logic                 pin_q, pin_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_PISO_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign bit_end = (cnt_q == COUNTER_W'(DIVIDER - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pin_d   = pin_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef UART_PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + COUNTER_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                pin_d   = 1'b1;
                ready_d = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    idx_d   = '0;
`ifdef UART_PISO_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = S_START;
                    pin_d   = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    pin_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == INDEX_W'(CHAR_W - 1)) begin
`ifdef UART_PISO_PARITY_EN
                        state_d = S_PARITY;
                        pin_d   = par_q;
`else
                        state_d = S_STOP;
                        pin_d   = 1'b1;
`endif
                    end else begin
                        // Next pin value is the post-shift LSB, so the line stays registered.
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + INDEX_W'(1);
                        pin_d   = shift_d[0];
                    end
                end
            end
`ifdef UART_PISO_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    pin_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                pin_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                pin_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef UART_PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign uart_tx_pin = pin_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = ~ready_q;
    assign tx_done     = done_q;

endmodule
